// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops a sync FIFO into a 2-entry buffer and presents it as a framed valid/ready stream
module fifo_stream_reader #(
  parameter int WIDTH = 8,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  input  logic             fifo_rd_error,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [15:0]      word_count,
  output logic             err,
  output logic             busy
);
  localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [1:0] occ, wr_slot;
  logic pending, hs, cap;
  logic [WIDTH-1:0] head, tail;
  logic [BW-1:0] burst_cnt;
  assign m_valid = occ != 2'd0;
  assign hs = m_valid && m_ready;
  assign cap = pending && !fifo_rd_error;
  assign wr_slot = occ - 2'(hs);
  assign fifo_rd_en = (state == RUN) && !fifo_empty && ({1'b0, occ} + 3'(pending)) < 3'd2 + 3'(hs);
  assign m_data = head;
  assign m_last = m_valid && burst_cnt == BW'(BURST_LEN - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      occ <= '0;
      pending <= 1'b0;
      head <= '0;
      tail <= '0;
      burst_cnt <= '0;
      word_count <= '0;
      err <= 1'b0;
    end else begin
      pending <= fifo_rd_en;
      occ <= occ + 2'(cap) - 2'(hs);
      if (hs) head <= tail;
      // an arriving word lands in the slot left free after this cycle's handshake
      if (cap && wr_slot == 2'd0) head <= fifo_rd_data;
      if (cap && wr_slot == 2'd1) tail <= fifo_rd_data;
      if (pending && fifo_rd_error) err <= 1'b1;
      if (hs) begin
        burst_cnt <= burst_cnt == BW'(BURST_LEN - 1) ? '0 : burst_cnt + 1'b1;
        word_count <= word_count + 16'd1;
      end
      case (state)
        IDLE: if (en) state <= RUN;
        RUN: if (!en) state <= (occ != 2'd0 || pending || fifo_rd_en) ? DRAIN : IDLE;
        DRAIN: if (en) state <= RUN; else if (occ == 2'd0 && !pending) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
